sap1_controller_sequencer: RTL

- SAP-1 control unit: a 6-state ring counter (T1..T6) plus a control matrix that decodes the opcode nibble from the instruction register.
- Drives the 12-bit SAP-1 control word: PC, MAR, RAM, IR, accumulator, ALU, B and output register strobes.
- Sits directly downstream of InstructionRegister: consumes its instr_out and generates its Li_bar/Ei_bar.
- Supports LDA, ADD, SUB, OUT, HLT; any other opcode executes as a NOP.

---
 rtl/sap1_controller_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer.
// A six-step ring counter (T1..T6) plus a HALT state, and a control matrix
// that decodes the ring state together with the opcode nibble from the
// instruction register into the 12-bit control word and the halt flag.
// The state register is the only storage in this block. The opcode is
// used directly because the IR holds it from T4 onward.
// There is no valid/ready handshake on this block: the strobes are
// level-valid for the whole cycle in which a state is held.
module sap1_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] opcode,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm_bar,
  output logic       CE_bar,
  output logic       Li_bar,
  output logic       Ei_bar,
  output logic       La_bar,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb_bar,
  output logic       Lo_bar,
  output logic       HLT,
  output logic [5:0] t_state
);

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_T6   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t state;

  // Ring counter: advance one T-step per clock, park in HALT on a HLT
  // opcode at T4, and return to T1 on CLR from any state.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= S_T1;
    end else begin
      case (state)
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3:    state <= S_T4;
        S_T4:    state <= (opcode == OP_HLT) ? S_HALT : S_T5;
        S_T5:    state <= S_T6;
        S_T6:    state <= S_T1;
        S_HALT:  state <= S_HALT;
        default: state <= S_T1;
      endcase
    end
  end

  // Control matrix: decode the held state and opcode into strobes. Every
  // signal starts inactive, so each case lists only what it asserts. Only
  // one bus driver (Ep, CE_bar, Ei_bar, Ea, Eu) is asserted in any step.
  always_comb begin
    Cp      = 1'b0;
    Ep      = 1'b0;
    Lm_bar  = 1'b1;
    CE_bar  = 1'b1;
    Li_bar  = 1'b1;
    Ei_bar  = 1'b1;
    La_bar  = 1'b1;
    Ea      = 1'b0;
    Su      = 1'b0;
    Eu      = 1'b0;
    Lb_bar  = 1'b1;
    Lo_bar  = 1'b1;
    HLT     = 1'b0;
    t_state = 6'b000000;

    if (CLR) begin
      // Reset forces T1 on the next edge, so show T1 with every strobe idle.
      t_state = 6'b000001;
    end else begin
      case (state)
        S_T1: begin
          t_state = 6'b000001;
          Ep      = 1'b1;
          Lm_bar  = 1'b0;
        end
        S_T2: begin
          t_state = 6'b000010;
          Cp      = 1'b1;
        end
        S_T3: begin
          t_state = 6'b000100;
          CE_bar  = 1'b0;
          Li_bar  = 1'b0;
        end
        S_T4: begin
          t_state = 6'b001000;
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            Ei_bar = 1'b0;
            Lm_bar = 1'b0;
          end else if (opcode == OP_OUT) begin
            Ea     = 1'b1;
            Lo_bar = 1'b0;
          end
        end
        S_T5: begin
          t_state = 6'b010000;
          if (opcode == OP_LDA) begin
            CE_bar = 1'b0;
            La_bar = 1'b0;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            CE_bar = 1'b0;
            Lb_bar = 1'b0;
          end
        end
        S_T6: begin
          t_state = 6'b100000;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            Eu     = 1'b1;
            La_bar = 1'b0;
            Su     = (opcode == OP_SUB);
          end
        end
        S_HALT: begin
          HLT = 1'b1;
        end
        default: begin
          t_state = 6'b000000;
        end
      endcase
    end
  end

endmodule
